puf_resp_collector: RTL
=======================

PUF_RESP_COLLECTOR -- requirements
Module: puf_resp_collector

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: cycles to wait after each sel change before sampling; legal range 1 or more.
REQ-002 Parameter SAMPLES, default 3: samples per bit for majority vote; SHALL be odd and 1 or more.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request one 16-bit acquisition; sampled only in IDLE.
REQ-006 bit_in  input  1  selected PUF cell bit, returned from the external 16:1 selector.
REQ-007 sel  output  4  index driven to the external 16:1 selector.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 resp  output  16  assembled response word; bit i is the voted value of cell i.
REQ-010 resp_valid  output  1  resp is complete and offered to the consumer.
REQ-011 resp_ready  input  1  consumer accepts resp.

Function
REQ-012 The FSM SHALL have the states IDLE, SETTLE, SAMPLE, STORE and DONE.
REQ-013 IDLE with start=1 SHALL go to SETTLE, set sel=0, clear the shadow word and clear all counters.
REQ-014 SETTLE SHALL last exactly SETTLE_CYCLES cycles with sel stable, then go to SAMPLE.
REQ-015 SAMPLE SHALL last exactly SAMPLES cycles, sample bit_in once per cycle and count ones; then go to STORE.
REQ-016 STORE SHALL last 1 cycle and write shadow[sel] = (ones > SAMPLES/2).
- If sel < 15: sel increments and the FSM goes to SETTLE.
- If sel = 15: the FSM goes to DONE.
REQ-017 On entry to DONE, resp SHALL load the full shadow word, including the bit just stored, and resp_valid SHALL rise.
REQ-018 Latency: resp_valid SHALL first be high 16*(SETTLE_CYCLES+SAMPLES+1) cycles after the edge that samples start (128 with the defaults).
REQ-019 DONE SHALL hold resp_valid=1 and resp stable until resp_valid and resp_ready are both high; the FSM then goes to IDLE on the next edge and resp_valid falls.
REQ-020 If resp_ready is already high on the first DONE cycle, the handshake SHALL complete in that cycle (DONE lasts 1 cycle).
REQ-021 start SHALL be ignored in every state other than IDLE, including the DONE handshake cycle; there is no queuing.
REQ-022 resp SHALL change only on entry to DONE and SHALL retain its value through IDLE and the next acquisition.
REQ-023 sel SHALL change only in STORE (increment) or on the IDLE-to-SETTLE transition (set to 0); it SHALL never wrap past 15 within one acquisition.
REQ-024 Majority counter width SHALL be clog2(SAMPLES+1); the settle counter width SHALL be clog2(SETTLE_CYCLES+1).

Reset
REQ-025 While rst_n=0, asynchronously: state=IDLE, sel=0, busy=0, resp=16'h0000, resp_valid=0, shadow word and all counters cleared.
REQ-026 Reset mid-acquisition SHALL discard partial results; the next start SHALL perform a full, fresh 16-bit acquisition.

Structure
REQ-027 Shared package puf_pkg SHALL hold the state enum type, RESP_W=16 and SEL_W=4.
REQ-028 One sub-module, puf_majority_vote (parameter SAMPLES; ports clear, sample_en, bit_in, vote), SHALL implement the ones counter and threshold compare.
REQ-029 Elaboration SHALL fail if SAMPLES is even or SAMPLES < 1, or if SETTLE_CYCLES < 1.

Verification
REQ-030 Model the 16:1 selector with cell pattern 16'hA5C3, defaults, pulse start -> sel steps 0..15, each held 8 cycles; resp=16'hA5C3; resp_valid exactly 128 cycles after start.
REQ-031 Noise at sel=5: samples 1,0,1 -> resp[5]=1; samples 0,1,0 -> resp[5]=0; all other bits match the model.
REQ-032 Backpressure: hold resp_ready=0 for 10 cycles in DONE and pulse start -> resp_valid and resp stay stable and start is ignored; raise resp_ready -> busy=0 on the next edge.
REQ-033 Assert rst_n=0 asynchronously while sel=7 -> all outputs 0 immediately; a new start then yields the correct full word.
REQ-034 Hold start=1 and resp_ready=1 continuously -> back-to-back acquisitions with start-to-start period 130 cycles (DONE 1 cycle, IDLE 1 cycle); resp is correct each time.
REQ-035 Pulse start during SAMPLE -> no effect on sel sequence, latency or resp.

Source files
------------

// File: rtl/puf_pkg.sv
// puf_pkg
//   Shared definitions for the PUF response collector.
//   RESP_W      : width of the assembled response word (one bit per PUF cell)
//   SEL_W       : width of the cell index driven to the external 16:1 selector
//   puf_state_e : collector FSM state encoding
package puf_pkg;

    localparam int RESP_W = 16;
    localparam int SEL_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_STORE  = 3'd3,
        ST_DONE   = 3'd4
    } puf_state_e;

endpackage

// File: rtl/puf_majority_vote.sv
// puf_majority_vote
//   Counts the ones seen on bit_in while sample_en is high and reports
//   whether they are a strict majority of SAMPLES.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear of the ones counter (wins over sample_en)
//   sample_en  : count bit_in on this edge
//   bit_in     : sampled cell bit
//   vote       : 1 when ones > SAMPLES/2 (combinational from the counter)
module puf_majority_vote #(
    parameter int SAMPLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic sample_en,
    input  logic bit_in,
    output logic vote
);

    localparam int CW = $clog2(SAMPLES + 1);

    logic [CW-1:0] ones;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones <= '0;
        end else if (clear) begin
            ones <= '0;
        end else if (sample_en && bit_in) begin
            ones <= ones + CW'(1);
        end
    end

    assign vote = (ones > CW'(SAMPLES / 2));

endmodule

// File: rtl/puf_resp_collector.sv
// puf_resp_collector
//   Walks the external 16:1 PUF selector through cells 0..15, lets each
//   selection settle, majority-votes SAMPLES reads of the cell and assembles
//   the 16-bit response, then offers it to a consumer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request one acquisition (only looked at in IDLE)
//   bit_in      : cell bit returned by the external selector
//   sel         : cell index driven to the external selector
//   busy        : high in every state except IDLE
//   resp        : last complete response word (held until the next one)
//   resp_valid  : resp is offered to the consumer
//   resp_ready  : consumer accepts resp
//   dbg_state   : current FSM state, for observation only
//
// Handshake: the response transfers on a rising edge where resp_valid and
// resp_ready are both high. While resp_valid is high, resp does not change
// and resp_valid stays high until that transfer; resp_ready may be high
// before resp_valid rises, in which case DONE lasts a single cycle.
module puf_resp_collector
    import puf_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLES       = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              bit_in,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic [RESP_W-1:0] resp,
    output logic              resp_valid,
    input  logic              resp_ready,
    output puf_state_e        dbg_state
);

    if ((SAMPLES % 2) == 0 || SAMPLES < 1) begin : g_bad_samples
        $error("puf_resp_collector: SAMPLES must be odd and at least 1");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("puf_resp_collector: SETTLE_CYCLES must be at least 1");
    end

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int SMP_W = $clog2(SAMPLES + 1);

    puf_state_e        state;
    logic [SET_W-1:0]  settle_cnt;
    logic [SMP_W-1:0]  samp_cnt;
    logic [RESP_W-1:0] shadow;
    logic [RESP_W-1:0] shadow_nxt;
    logic              vote;
    logic              vote_clear;
    logic              vote_en;

    // The ones counter is held clear while idle and while settling, so every
    // cell starts its SAMPLE window from zero without a separate clear pulse.
    assign vote_clear = (state == ST_IDLE) || (state == ST_SETTLE);
    assign vote_en    = (state == ST_SAMPLE);

    puf_majority_vote #(
        .SAMPLES (SAMPLES)
    ) u_vote (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (vote_clear),
        .sample_en (vote_en),
        .bit_in    (bit_in),
        .vote      (vote)
    );

    // Shadow word with the current cell's vote merged in; used both for the
    // shadow update and for loading resp, so the last bit is not lost.
    always_comb begin
        shadow_nxt      = shadow;
        shadow_nxt[sel] = vote;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sel        <= '0;
            resp       <= '0;
            shadow     <= '0;
            settle_cnt <= '0;
            samp_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_SETTLE;
                        sel        <= '0;
                        shadow     <= '0;
                        settle_cnt <= '0;
                        samp_cnt   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
                        settle_cnt <= '0;
                        state      <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (samp_cnt == SMP_W'(SAMPLES - 1)) begin
                        samp_cnt <= '0;
                        state    <= ST_STORE;
                    end else begin
                        samp_cnt <= samp_cnt + SMP_W'(1);
                    end
                end
                ST_STORE: begin
                    shadow <= shadow_nxt;
                    if (sel == '1) begin
                        resp  <= shadow_nxt;
                        state <= ST_DONE;
                    end else begin
                        sel   <= sel + SEL_W'(1);
                        state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = (state != ST_IDLE);
    assign resp_valid = (state == ST_DONE);
    assign dbg_state  = state;

endmodule
